fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch entry type for the instruction-fetch stage.
package fetch_pkg;
    localparam int              ADDR_W   = 32;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;
    localparam int              PC_STEP  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of fetch entries; flush empties it in one cycle and wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    fetch_entry_t    mem_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;

    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    // Head is driven straight from storage so decode never sees a path from its own ready.
    assign head  = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirects and a prefetch queue toward decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);
    logic [ADDR_W-1:0] fetch_pc_reg;
    fetch_entry_t      head;
    fetch_entry_t      wr_entry;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_addr      = fetch_pc_reg;
    assign id_valid       = ~empty;
    assign pop            = id_valid & id_ready;
    assign push           = ~redirect_valid & (~full | pop);
    assign wr_entry.pc    = fetch_pc_reg;
    assign wr_entry.instr = imem_rdata;

    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_pc_plus4 = empty ? '0 : head.pc + ADDR_W'(PC_STEP);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            fetch_pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_reg <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(PC_STEP);
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (CLK),
        .rst_n    (RSTn),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (push && (perf_fetched_reg != 32'hFFFF_FFFF)) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (full && !pop && !redirect_valid && (perf_stall_reg != 32'hFFFF_FFFF)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-addressed big-endian memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];

    always #5 CLK = ~CLK;

    always_comb begin
        imem_rdata = {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
                      mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]};
    end

    fetch_unit #(.QDEPTH(2)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
        total++; if (id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", id_pc_plus4); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== 32'h0) begin bad++; $display("FAIL rst_pf got=%h exp=0", perf_fetched); end
        total++; if (perf_stall !== 32'h0) begin bad++; $display("FAIL rst_ps got=%h exp=0", perf_stall); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_seq_fetch();
        RSTn = 1'b1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL seq_nobypass got=%b exp=0", id_valid); end
        step();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_v0 got=%b exp=1", id_valid); end
        total++; if (id_instr !== 32'h00A0F809) begin bad++; $display("FAIL seq_i0 got=%h exp=00a0f809", id_instr); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL seq_pc0 got=%h exp=0", id_pc); end
        total++; if (id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL seq_pc4_0 got=%h exp=4", id_pc_plus4); end
        step();
        total++; if (id_instr !== 32'h00874022) begin bad++; $display("FAIL seq_i1 got=%h exp=00874022", id_instr); end
        total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL seq_pc1 got=%h exp=4", id_pc); end
        total++; if (id_pc_plus4 !== 32'h8) begin bad++; $display("FAIL seq_pc4_1 got=%h exp=8", id_pc_plus4); end
        $display("test_seq_fetch done");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_instr [4];
        exp_instr = '{32'h00A0F809, 32'h00874022, 32'hA500_0008, 32'hA500_000C};
        RSTn = 1'b0; id_ready = 1'b0;
        step();
        RSTn = 1'b1;
        step(); step();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_fill_addr got=%h exp=8", imem_addr); end
        step(); step(); step();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_freeze_addr got=%h exp=8", imem_addr); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", id_valid); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd2) begin bad++; $display("FAIL bp_pf got=%0d exp=2", perf_fetched); end
        total++; if (perf_stall !== 32'd3) begin bad++; $display("FAIL bp_ps got=%0d exp=3", perf_stall); end
`endif
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL bp_drain_v%0d got=%b exp=1", i, id_valid); end
            total++; if (id_pc !== 32'(i * 4)) begin bad++; $display("FAIL bp_drain_pc%0d got=%h exp=%h", i, id_pc, 32'(i * 4)); end
            total++; if (id_instr !== exp_instr[i]) begin bad++; $display("FAIL bp_drain_i%0d got=%h exp=%h", i, id_instr, exp_instr[i]); end
            step();
        end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect();
        redirect_to(32'h18);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rd_flush got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h18) begin bad++; $display("FAIL rd_addr got=%h exp=18", imem_addr); end
        step();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL rd_v got=%b exp=1", id_valid); end
        total++; if (id_pc !== 32'h18) begin bad++; $display("FAIL rd_pc got=%h exp=18", id_pc); end
        total++; if (id_instr !== 32'h12EE0002) begin bad++; $display("FAIL rd_i got=%h exp=12ee0002", id_instr); end
        total++; if (id_pc_plus4 !== 32'h1C) begin bad++; $display("FAIL rd_pc4 got=%h exp=1c", id_pc_plus4); end
        step();
        total++; if (id_pc !== 32'h1C) begin bad++; $display("FAIL rd_pc_next got=%h exp=1c", id_pc); end
        $display("test_redirect done");
    endtask

    task automatic test_misaligned();
        redirect_to(32'h1D);
        total++; if (imem_addr !== 32'h1C) begin bad++; $display("FAIL mis_addr got=%h exp=1c", imem_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL mis_flush got=%b exp=0", id_valid); end
        step();
        total++; if (id_pc !== 32'h1C) begin bad++; $display("FAIL mis_pc got=%h exp=1c", id_pc); end
        total++; if (id_instr !== 32'h08000001) begin bad++; $display("FAIL mis_i got=%h exp=08000001", id_instr); end
        $display("test_misaligned done");
    endtask

    task automatic test_redirect_full();
        id_ready = 1'b0;
        step(); step(); step();
        total++; if (imem_addr !== 32'h24) begin bad++; $display("FAIL rf_full_addr got=%h exp=24", imem_addr); end
        id_ready = 1'b1;
        redirect_to(32'h40);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rf_flush got=%b exp=0", id_valid); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL rf_addr got=%h exp=40", imem_addr); end
        step();
        total++; if (id_pc !== 32'h40) begin bad++; $display("FAIL rf_pc got=%h exp=40", id_pc); end
        total++; if (id_instr !== 32'hA500_0040) begin bad++; $display("FAIL rf_i got=%h exp=a5000040", id_instr); end
        $display("test_redirect_full done");
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_pc = 32'h90;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'h90) begin bad++; $display("FAIL b2b_addr got=%h exp=90", imem_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL b2b_flush got=%b exp=0", id_valid); end
        step();
        total++; if (id_pc !== 32'h90) begin bad++; $display("FAIL b2b_pc got=%h exp=90", id_pc); end
        total++; if (id_instr !== 32'hA500_0090) begin bad++; $display("FAIL b2b_i got=%h exp=a5000090", id_instr); end
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFE);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr got=%h exp=fffffffc", imem_addr); end
        step();
        total++; if (id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_pc got=%h exp=fffffffc", id_pc); end
        total++; if (id_instr !== 32'hA500_00FC) begin bad++; $display("FAIL wr_i got=%h exp=a50000fc", id_instr); end
        total++; if (id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wr_pc4 got=%h exp=0", id_pc_plus4); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wr_next_addr got=%h exp=0", imem_addr); end
        step();
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL wr_pc_after got=%h exp=0", id_pc); end
        $display("test_wrap done");
    endtask

    task automatic test_midstream_reset();
        id_ready = 1'b0;
        step(); step();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL mr_prefill got=%b exp=1", id_valid); end
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", id_valid); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL mr_addr got=%h exp=%h", imem_addr, RESET_PC); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL mr_pc_empty got=%h exp=0", id_pc); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== 32'h0) begin bad++; $display("FAIL mr_pf got=%h exp=0", perf_fetched); end
        total++; if (perf_stall !== 32'h0) begin bad++; $display("FAIL mr_ps got=%h exp=0", perf_stall); end
`endif
        id_ready = 1'b1;
        step();
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL mr_pc0 got=%h exp=0", id_pc); end
        total++; if (id_instr !== 32'h00A0F809) begin bad++; $display("FAIL mr_i0 got=%h exp=00a0f809", id_instr); end
        step();
        total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL mr_pc1 got=%h exp=4", id_pc); end
        $display("test_midstream_reset done");
    endtask

    initial begin
        for (int a = 0; a < 256; a += 4) begin
            logic [31:0] w;
            w = 32'hA500_0000 | 32'(a);
            mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
        end
        mem[0]  = 8'h00; mem[1]  = 8'hA0; mem[2]  = 8'hF8; mem[3]  = 8'h09;
        mem[4]  = 8'h00; mem[5]  = 8'h87; mem[6]  = 8'h40; mem[7]  = 8'h22;
        mem[24] = 8'h12; mem[25] = 8'hEE; mem[26] = 8'h00; mem[27] = 8'h02;
        mem[28] = 8'h08; mem[29] = 8'h00; mem[30] = 8'h00; mem[31] = 8'h01;

        test_reset();
        test_seq_fetch();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_midstream_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
